// File: rtl/reg16_byte_sequencer.sv
// Byte-wide front end for a 16-bit register: assembles two bus bytes into one commit,
// performs in-place increments and serialises the register back onto the 8-bit bus.
module reg16_byte_sequencer #(
  parameter bit          LOW_FIRST = 1'b1,
  parameter logic [15:0] INC_STEP  = 16'd1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        wr_valid,
  input  logic [7:0]  wr_byte,
  output logic        wr_ready,
  input  logic        inc_req,
  output logic        inc_ready,
  input  logic        rd_req,
  output logic        rd_valid,
  output logic [7:0]  rd_byte,
  input  logic [15:0] reg_q,
  output logic [15:0] reg_d,
  output logic        reg_ce,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, HALF, COMMIT, RD1, RD2} state_t;

  state_t      state;
  logic [7:0]  held;
  logic [15:0] snap;

  function automatic logic [15:0] assemble(input logic [7:0] first, input logic [7:0] second);
    return LOW_FIRST ? {second, first} : {first, second};
  endfunction

  function automatic logic [7:0] first_byte(input logic [15:0] word);
    return LOW_FIRST ? word[7:0] : word[15:8];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] word);
    return LOW_FIRST ? word[15:8] : word[7:0];
  endfunction

  // Handshake readies are combinational so a byte or inc is taken in the cycle it is offered.
  assign wr_ready  = (state == IDLE) || (state == HALF);
  assign inc_ready = (state == IDLE) && !wr_valid;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      held     <= 8'h00;
      snap     <= 16'h0000;
      reg_d    <= 16'h0000;
      reg_ce   <= 1'b0;
      rd_valid <= 1'b0;
      rd_byte  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      reg_ce   <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_valid) begin
            held  <= wr_byte;
            state <= HALF;
            busy  <= 1'b1;
          end else if (inc_req) begin
            reg_d  <= reg_q + INC_STEP;
            reg_ce <= 1'b1;
            state  <= COMMIT;
            busy   <= 1'b1;
          end else if (rd_req) begin
            // First byte goes out straight from reg_q; the snapshot keeps the pair coherent.
            snap     <= reg_q;
            rd_byte  <= first_byte(reg_q);
            rd_valid <= 1'b1;
            state    <= RD1;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        HALF: begin
          busy <= 1'b1;
          if (wr_valid) begin
            reg_d  <= assemble(held, wr_byte);
            reg_ce <= 1'b1;
            state  <= COMMIT;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        RD1: begin
          rd_byte  <= second_byte(snap);
          rd_valid <= 1'b1;
          state    <= RD2;
          busy     <= 1'b1;
        end
        RD2: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg16_byte_sequencer.sv
// Directed bench for reg16_byte_sequencer (LOW_FIRST=1, INC_STEP=1) with a behavioural
// 16-bit register closing the reg_d/reg_ce -> reg_q loop.
module tb_reg16_byte_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        wr_valid;
  logic [7:0]  wr_byte;
  logic        wr_ready;
  logic        inc_req;
  logic        inc_ready;
  logic        rd_req;
  logic        rd_valid;
  logic [7:0]  rd_byte;
  logic [15:0] reg_q;
  logic [15:0] reg_d;
  logic        reg_ce;
  logic        busy;

  logic        preload;
  logic [15:0] preload_val;

  int n_tests = 0;
  int n_fail  = 0;

  reg16_byte_sequencer #(.LOW_FIRST(1'b1), .INC_STEP(16'd1)) dut (
    .clock(clock), .clear(clear),
    .wr_valid(wr_valid), .wr_byte(wr_byte), .wr_ready(wr_ready),
    .inc_req(inc_req), .inc_ready(inc_ready),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_byte(rd_byte),
    .reg_q(reg_q), .reg_d(reg_d), .reg_ce(reg_ce), .busy(busy)
  );

  always #5 clock = ~clock;

  // The external 16-bit register, with a bench-only preload path.
  always @(posedge clock) begin
    if (preload)     reg_q <= preload_val;
    else if (reg_ce) reg_q <= reg_d;
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_reg(input logic [15:0] v);
    preload = 1'b1; preload_val = v;
    tick();
    preload = 1'b0;
  endtask

  initial begin
    clear = 1'b1; wr_valid = 1'b1; wr_byte = 8'h55; inc_req = 1'b0; rd_req = 1'b0;
    preload = 1'b1; preload_val = 16'h0000;
    tick();
    preload = 1'b0;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_ce", 16'(reg_ce), 16'h0);
    chk("rst_rdv", 16'(rd_valid), 16'h0);
    chk("rst_rdb", 16'(rd_byte), 16'h00);
    chk("rst_regd", reg_d, 16'h0000);
    chk("rst_wrdy", 16'(wr_ready), 16'h1);
    clear = 1'b0; wr_valid = 1'b0;
    #1;
    chk("idle_incrdy", 16'(inc_ready), 16'h1);

    // Back-to-back write 0x34, 0x12
    wr_valid = 1'b1; wr_byte = 8'h34;
    #1 chk("w1_incrdy", 16'(inc_ready), 16'h0);
    tick();
    chk("w1_busy", 16'(busy), 16'h1);
    chk("w1_ce_half", 16'(reg_ce), 16'h0);
    wr_byte = 8'h12;
    tick();
    wr_valid = 1'b0;
    chk("w1_ce", 16'(reg_ce), 16'h1);
    chk("w1_regd", reg_d, 16'h1234);
    #1 chk("w1_wrdy_commit", 16'(wr_ready), 16'h0);
    tick();
    chk("w1_ce_off", 16'(reg_ce), 16'h0);
    chk("w1_regq", reg_q, 16'h1234);
    chk("w1_idle", 16'(busy), 16'h0);

    // Write with a 5-cycle gap between bytes
    wr_valid = 1'b1; wr_byte = 8'hCD;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_ce", 16'(reg_ce), 16'h0);
      chk("gap_busy", 16'(busy), 16'h1);
    end
    wr_valid = 1'b1; wr_byte = 8'hAB;
    tick();
    wr_valid = 1'b0;
    chk("gap_ce_pulse", 16'(reg_ce), 16'h1);
    chk("gap_regd", reg_d, 16'hABCD);
    tick();
    chk("gap_ce_once", 16'(reg_ce), 16'h0);
    chk("gap_regq", reg_q, 16'hABCD);

    // Increment wrap
    load_reg(16'hFFFF);
    inc_req = 1'b1;
    #1 chk("inc_rdy", 16'(inc_ready), 16'h1);
    tick();
    inc_req = 1'b0;
    chk("inc_ce", 16'(reg_ce), 16'h1);
    chk("inc_wrap", reg_d, 16'h0000);
    tick();
    chk("inc_ce_once", 16'(reg_ce), 16'h0);
    chk("inc_regq", reg_q, 16'h0000);

    // Write has priority over a held increment; inc serviced afterwards
    wr_valid = 1'b1; wr_byte = 8'h34; inc_req = 1'b1;
    #1 chk("pri_incrdy", 16'(inc_ready), 16'h0);
    tick();
    chk("pri_incrdy_half", 16'(inc_ready), 16'h0);
    wr_byte = 8'h12;
    tick();
    wr_valid = 1'b0;
    chk("pri_wr_regd", reg_d, 16'h1234);
    tick();
    chk("pri_regq_w", reg_q, 16'h1234);
    chk("pri_incrdy_idle", 16'(inc_ready), 16'h1);
    tick();
    inc_req = 1'b0;
    chk("pri_inc_ce", 16'(reg_ce), 16'h1);
    chk("pri_inc_regd", reg_d, 16'h1235);
    tick();
    chk("pri_regq_inc", reg_q, 16'h1235);

    // Read-back, with reg_q changed mid-read to prove the snapshot
    load_reg(16'hBEEF);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("rd1_vld", 16'(rd_valid), 16'h1);
    chk("rd1_byte", 16'(rd_byte), 16'h00EF);
    chk("rd1_wrdy", 16'(wr_ready), 16'h0);
    preload = 1'b1; preload_val = 16'h0000;
    tick();
    preload = 1'b0;
    chk("rd2_vld", 16'(rd_valid), 16'h1);
    chk("rd2_byte", 16'(rd_byte), 16'h00BE);
    chk("rd2_busy", 16'(busy), 16'h1);
    chk("rd_no_ce", 16'(reg_ce), 16'h0);
    tick();
    chk("rd_done_vld", 16'(rd_valid), 16'h0);
    chk("rd_hold_byte", 16'(rd_byte), 16'h00BE);
    chk("rd_done_busy", 16'(busy), 16'h0);

    // Clear in HALF aborts the write
    wr_valid = 1'b1; wr_byte = 8'h77;
    tick();
    wr_valid = 1'b0;
    chk("clr_half_busy", 16'(busy), 16'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 16'(busy), 16'h0);
    chk("clr_regd", reg_d, 16'h0000);
    chk("clr_ce", 16'(reg_ce), 16'h0);
    tick();
    chk("clr_no_ce", 16'(reg_ce), 16'h0);
    chk("clr_idle", 16'(busy), 16'h0);
    wr_valid = 1'b1; wr_byte = 8'h11;
    tick();
    wr_byte = 8'h22;
    tick();
    wr_valid = 1'b0;
    chk("post_clr_regd", reg_d, 16'h2211);
    chk("post_clr_ce", 16'(reg_ce), 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
